// File: rtl/vc_dest_router_pkg.sv
// vc_dest_router_pkg
// Shared types for the VC-to-destination router: FSM state encoding and the
// encoding used to remember which virtual channel a word was popped from.
package vc_dest_router_pkg;

    typedef enum logic [1:0] {
        StInit   = 2'd0,
        StIdle   = 2'd1,
        StActive = 2'd2
    } state_e;

    typedef enum logic {
        VcSel0 = 1'b0,
        VcSel1 = 1'b1
    } vc_sel_e;

endpackage

// File: rtl/vc_dest_router_if.sv
// vc_dest_router_if
// Bundles the source-FIFO, destination-FIFO and status signals of the router.
//   master : router side (drives pop strobes, push strobes/data, status)
//   slave  : FIFO/environment side (drives flags and source read data)
// Signal names match the FIFO wrapper ports they connect to.
interface vc_dest_router_if #(
    parameter int unsigned BW = 6
) ();

    // Source virtual-channel FIFOs
    logic          vc0_empty;
    logic          vc1_empty;
    logic [BW-1:0] vc0_data_out;
    logic [BW-1:0] vc1_data_out;
    logic          vc0_rd;
    logic          vc1_rd;

    // Destination FIFOs
    logic          D0_almost_full;
    logic          D1_almost_full;
    logic          D0_full;
    logic          D1_full;
    logic          D0_wr;
    logic          D1_wr;
    logic [BW-1:0] D0_data_in;
    logic [BW-1:0] D1_data_in;

    // Status
    logic          route_error;
    logic          active;

    modport master (
        input  vc0_empty, vc1_empty, vc0_data_out, vc1_data_out,
        input  D0_almost_full, D1_almost_full, D0_full, D1_full,
        output vc0_rd, vc1_rd,
        output D0_wr, D1_wr, D0_data_in, D1_data_in,
        output route_error, active
    );

    modport slave (
        output vc0_empty, vc1_empty, vc0_data_out, vc1_data_out,
        output D0_almost_full, D1_almost_full, D0_full, D1_full,
        input  vc0_rd, vc1_rd,
        input  D0_wr, D1_wr, D0_data_in, D1_data_in,
        input  route_error, active
    );

endinterface

// File: rtl/vc_dest_stats.sv
// vc_dest_stats
// Four 8-bit wrapping event counters for the router: words popped per VC and
// words written per destination. Only present when VC_DEST_ROUTER_STATS_EN is
// defined; otherwise this file contributes no module.
// Ports:
//   clk, reset_L            : clock, synchronous active-low reset
//   vc0_rd_i, vc1_rd_i      : source pop strobes
//   d0_wr_i, d1_wr_i        : destination push strobes (after error suppression)
//   cnt_*_o                 : counter values, wrap 255 -> 0
`ifdef VC_DEST_ROUTER_STATS_EN
module vc_dest_stats (
    input  logic       clk,
    input  logic       reset_L,
    input  logic       vc0_rd_i,
    input  logic       vc1_rd_i,
    input  logic       d0_wr_i,
    input  logic       d1_wr_i,
    output logic [7:0] cnt_vc0_o,
    output logic [7:0] cnt_vc1_o,
    output logic [7:0] cnt_d0_o,
    output logic [7:0] cnt_d1_o
);

    logic [7:0] cnt_vc0_q, cnt_vc1_q, cnt_d0_q, cnt_d1_q;

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            cnt_vc0_q <= 8'd0;
            cnt_vc1_q <= 8'd0;
            cnt_d0_q  <= 8'd0;
            cnt_d1_q  <= 8'd0;
        end else begin
            if (vc0_rd_i) cnt_vc0_q <= cnt_vc0_q + 8'd1;
            if (vc1_rd_i) cnt_vc1_q <= cnt_vc1_q + 8'd1;
            if (d0_wr_i)  cnt_d0_q  <= cnt_d0_q + 8'd1;
            if (d1_wr_i)  cnt_d1_q  <= cnt_d1_q + 8'd1;
        end
    end

    assign cnt_vc0_o = cnt_vc0_q;
    assign cnt_vc1_o = cnt_vc1_q;
    assign cnt_d0_o  = cnt_d0_q;
    assign cnt_d1_o  = cnt_d1_q;

endmodule
`endif

// File: rtl/vc_dest_router.sv
// vc_dest_router
// Pops words from VC0 (strict priority) or VC1 and steers each into
// destination FIFO D0 or D1 according to word[DEST_BIT]. Two-stage pipeline:
//   stage 1 : remembers that a pop happened and from which VC
//   stage 2 : captures the source read data and decodes the destination
// A pop is only issued when neither destination is almost full, so at most
// two words are ever in flight. Writes into a full destination are dropped and
// latch route_error until reset.
// Ports:
//   clk, reset_L : clock, synchronous active-low reset
//   bus          : vc_dest_router_if.master (FIFO flags/data, strobes, status)
//   cnt_vc0/vc1/d0/d1 : event counters, only with VC_DEST_ROUTER_STATS_EN
// Parameters: BW word width, DEST_BIT index of destination-select bit.
module vc_dest_router
    import vc_dest_router_pkg::*;
#(
    parameter int unsigned BW       = 6,
    parameter int unsigned DEST_BIT = 4
) (
    input  logic             clk,
    input  logic             reset_L,
    vc_dest_router_if.master bus
`ifdef VC_DEST_ROUTER_STATS_EN
    ,
    output logic [7:0]       cnt_vc0,
    output logic [7:0]       cnt_vc1,
    output logic [7:0]       cnt_d0,
    output logic [7:0]       cnt_d1
`endif
);

    state_e        state_q;

    logic          issue;
    logic          rd_any;

    logic          sel_valid_q;
    vc_sel_e       sel_vc_q;
    logic          s2_valid_q;
    logic          s2_dest_q;
    logic [BW-1:0] d0_data_q;
    logic [BW-1:0] d1_data_q;
    logic          route_error_q;
    logic          active_q;

    logic [BW-1:0] s1_word;
    logic          s1_dest;
    logic          d0_wr_req;
    logic          d1_wr_req;
    logic          d0_drop;
    logic          d1_drop;

    // ------------------------------------------------------------------
    // Read issue: combinational from registered state and the almost-full
    // flags. reset_L gating keeps the strobes low while reset is held, even
    // before the first edge has loaded state_q.
    // ------------------------------------------------------------------
    assign issue = reset_L && (state_q != StInit) &&
                   !bus.D0_almost_full && !bus.D1_almost_full;

    assign bus.vc0_rd = issue && !bus.vc0_empty;
    assign bus.vc1_rd = issue && bus.vc0_empty && !bus.vc1_empty;
    assign rd_any     = bus.vc0_rd || bus.vc1_rd;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q <= StInit;
        end else begin
            case (state_q)
                StInit:   state_q <= StIdle;
                StIdle:   if (rd_any) state_q <= StActive;
                StActive: if (!rd_any && !sel_valid_q && !s2_valid_q) state_q <= StIdle;
                default:  state_q <= StInit;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    // Source read data is valid the cycle after the pop, i.e. while stage 1
    // holds the selection.
    assign s1_word = (sel_vc_q == VcSel1) ? bus.vc1_data_out : bus.vc0_data_out;
    assign s1_dest = s1_word[DEST_BIT];

    assign d0_wr_req = s2_valid_q && !s2_dest_q;
    assign d1_wr_req = s2_valid_q && s2_dest_q;

    // Full is checked in the cycle the strobe would be seen by the FIFO.
    assign d0_drop = d0_wr_req && bus.D0_full;
    assign d1_drop = d1_wr_req && bus.D1_full;

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            sel_valid_q   <= 1'b0;
            sel_vc_q      <= VcSel0;
            s2_valid_q    <= 1'b0;
            s2_dest_q     <= 1'b0;
            d0_data_q     <= '0;
            d1_data_q     <= '0;
            route_error_q <= 1'b0;
            active_q      <= 1'b0;
        end else begin
            sel_valid_q <= rd_any;
            sel_vc_q    <= bus.vc1_rd ? VcSel1 : VcSel0;

            s2_valid_q <= sel_valid_q;
            if (sel_valid_q) begin
                s2_dest_q <= s1_dest;
                // Only the selected destination's data register moves.
                if (s1_dest) begin
                    d1_data_q <= s1_word;
                end else begin
                    d0_data_q <= s1_word;
                end
            end

            if (d0_drop || d1_drop) begin
                route_error_q <= 1'b1;
            end

            active_q <= sel_valid_q || s2_valid_q || rd_any;
        end
    end

    assign bus.D0_wr       = d0_wr_req && !bus.D0_full;
    assign bus.D1_wr       = d1_wr_req && !bus.D1_full;
    assign bus.D0_data_in  = d0_data_q;
    assign bus.D1_data_in  = d1_data_q;
    assign bus.route_error = route_error_q;
    assign bus.active      = active_q;

`ifdef VC_DEST_ROUTER_STATS_EN
    vc_dest_stats u_stats (
        .clk       (clk),
        .reset_L   (reset_L),
        .vc0_rd_i  (bus.vc0_rd),
        .vc1_rd_i  (bus.vc1_rd),
        .d0_wr_i   (bus.D0_wr),
        .d1_wr_i   (bus.D1_wr),
        .cnt_vc0_o (cnt_vc0),
        .cnt_vc1_o (cnt_vc1),
        .cnt_d0_o  (cnt_d0),
        .cnt_d1_o  (cnt_d1)
    );
`endif

endmodule

// File: tb/tb_vc_dest_router.sv
// tb_vc_dest_router
// Scoreboard bench for vc_dest_router. Source FIFOs are modelled as arrays
// with read/write pointers; every pushed word that should reach a destination
// is queued on that destination's expected queue, and a monitor pops and
// compares whenever the DUT strobes D0_wr/D1_wr. Directed sequences add
// cycle-exact checks for reset release, latency, backpressure and errors.
module tb_vc_dest_router;

    logic clk = 1'b0;
    logic reset_L = 1'b0;
    always #5 clk = ~clk;

    vc_dest_router_if #(.BW(6)) bus ();

`ifdef VC_DEST_ROUTER_STATS_EN
    logic [7:0] cnt_vc0, cnt_vc1, cnt_d0, cnt_d1;
`endif

    vc_dest_router #(.BW(6), .DEST_BIT(4)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
`ifdef VC_DEST_ROUTER_STATS_EN
        ,
        .cnt_vc0 (cnt_vc0),
        .cnt_vc1 (cnt_vc1),
        .cnt_d0  (cnt_d0),
        .cnt_d1  (cnt_d1)
`endif
    );

    // Source FIFO models
    logic [5:0]  mem0 [0:1023];
    logic [5:0]  mem1 [0:1023];
    int unsigned wp0 = 0, rp0 = 0, wp1 = 0, rp1 = 0;
    logic [5:0]  q0 = 6'd0, q1 = 6'd0;

    assign bus.vc0_empty    = (wp0 == rp0);
    assign bus.vc1_empty    = (wp1 == rp1);
    assign bus.vc0_data_out = q0;
    assign bus.vc1_data_out = q1;

    always @(posedge clk) begin
        if (bus.vc0_rd) begin
            q0  <= mem0[rp0[9:0]];
            rp0 <= rp0 + 1;
        end
        if (bus.vc1_rd) begin
            q1  <= mem1[rp1[9:0]];
            rp1 <= rp1 + 1;
        end
    end

    // Scoreboard
    logic [5:0] exp_d0 [$];
    logic [5:0] exp_d1 [$];
    int checks = 0;
    int errors = 0;
    int vc1_pops = 0;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic push(input int vc, input logic [5:0] w, input bit exp_wr);
        if (vc == 0) begin
            mem0[wp0[9:0]] = w;
            wp0++;
        end else begin
            mem1[wp1[9:0]] = w;
            wp1++;
        end
        if (exp_wr) begin
            if (w[4]) exp_d1.push_back(w);
            else      exp_d0.push_back(w);
        end
    endtask

    // Monitor
    always begin
        @(negedge clk);
        #2;
        if (reset_L) begin
            if (bus.D0_wr) begin
                if (exp_d0.size() == 0) check("d0_wr_unexpected", int'(bus.D0_wr), 0);
                else check("d0_data", int'(bus.D0_data_in), int'(exp_d0.pop_front()));
            end
            if (bus.D1_wr) begin
                if (exp_d1.size() == 0) check("d1_wr_unexpected", int'(bus.D1_wr), 0);
                else check("d1_data", int'(bus.D1_data_in), int'(exp_d1.pop_front()));
            end
            if (bus.D0_wr || bus.D1_wr) begin
                check("wr_overlap", int'(bus.D0_wr && bus.D1_wr), 0);
            end
            if (bus.vc0_rd || bus.vc1_rd) begin
                check("rd_onehot", int'(bus.vc0_rd && bus.vc1_rd), 0);
            end
            if (bus.vc1_rd) begin
                vc1_pops++;
                check("vc1_rd_while_vc0_nonempty", int'(bus.vc0_empty), 1);
            end
        end
    end

    // Wait (bounded) for all expected words to be written and the pipe idle.
    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_d0.size() == 0 && exp_d1.size() == 0 && !bus.active &&
                bus.vc0_empty && bus.vc1_empty) break;
            @(negedge clk);
            #1;
        end
        check("drain_pending", exp_d0.size() + exp_d1.size(), 0);
        check("drain_idle", int'(bus.active), 0);
    endtask

    int nwr, nrd;

    initial begin
        bus.D0_almost_full = 1'b0;
        bus.D1_almost_full = 1'b0;
        bus.D0_full        = 1'b0;
        bus.D1_full        = 1'b0;

        // Reset held 3 cycles with VC0 non-empty
        push(0, 6'h0A, 1'b1);
        repeat (3) begin
            @(negedge clk);
            #1;
            check("reset_outputs", int'({bus.vc0_rd, bus.vc1_rd, bus.D0_wr, bus.D1_wr,
                                         bus.D0_data_in, bus.D1_data_in,
                                         bus.route_error, bus.active}), 0);
        end
        reset_L = 1'b1;
        #1;
        check("no_rd_first_cycle", int'(bus.vc0_rd), 0);
        @(negedge clk);
        #1;
        check("first_vc0_rd", int'(bus.vc0_rd), 1);
        drain(20);

        // Latency: 6'h12 -> D1 at N+2, 6'h03 -> D0 at N+3
        push(0, 6'h12, 1'b1);
        push(0, 6'h03, 1'b1);
        #1;
        check("lat_rd_n", int'(bus.vc0_rd), 1);
        @(negedge clk);
        #1;
        check("lat_active_n1", int'(bus.active), 1);
        @(negedge clk);
        #1;
        check("lat_d1_wr_n2", int'(bus.D1_wr), 1);
        check("lat_d1_data_n2", int'(bus.D1_data_in), 'h12);
        check("lat_d0_idle_n2", int'(bus.D0_wr), 0);
        @(negedge clk);
        #1;
        check("lat_d0_wr_n3", int'(bus.D0_wr), 1);
        check("lat_d0_data_n3", int'(bus.D0_data_in), 'h03);
        check("lat_d1_idle_n3", int'(bus.D1_wr), 0);
        drain(20);

        // Both VCs loaded: VC0 drains first, per-destination order kept
        vc1_pops = 0;
        push(0, 6'h11, 1'b1);
        push(0, 6'h02, 1'b1);
        push(0, 6'h13, 1'b1);
        push(0, 6'h04, 1'b1);
        push(1, 6'h05, 1'b1);
        push(1, 6'h16, 1'b1);
        push(1, 6'h07, 1'b1);
        push(1, 6'h18, 1'b1);
        drain(30);
        check("vc1_pops", vc1_pops, 4);

        // Almost-full backpressure mid-stream
        for (int i = 0; i < 6; i++) push(0, 6'(8'h21 + i), 1'b1);
        @(negedge clk);
        @(negedge clk);
        bus.D0_almost_full = 1'b1;
        nwr = 0;
        nrd = 0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            nwr += int'(bus.D0_wr) + int'(bus.D1_wr);
            nrd += int'(bus.vc0_rd) + int'(bus.vc1_rd);
        end
        check("af_no_rd", nrd, 0);
        check("af_inflight_writes", nwr, 2);
        @(negedge clk);
        bus.D0_almost_full = 1'b0;
        #1;
        check("af_resume_rd", int'(bus.vc0_rd), 1);
        drain(30);

        // Write into full D1: dropped, sticky route_error
        bus.D1_full = 1'b1;
        push(0, 6'h15, 1'b0);
        repeat (5) @(negedge clk);
        #1;
        check("route_error_set", int'(bus.route_error), 1);
        push(0, 6'h01, 1'b1);
        drain(20);
        check("route_error_sticky", int'(bus.route_error), 1);
        @(negedge clk);
        reset_L = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_L     = 1'b1;
        bus.D1_full = 1'b0;
        #1;
        check("route_error_cleared", int'(bus.route_error), 0);

`ifdef VC_DEST_ROUTER_STATS_EN
        // 300 words to D0: 8-bit counters wrap to 44
        for (int i = 0; i < 300; i++) push(0, 6'(i % 16), 1'b1);
        drain(400);
        check("cnt_d0", int'(cnt_d0), 44);
        check("cnt_vc0", int'(cnt_vc0), 44);
        check("cnt_d1", int'(cnt_d1), 0);
        check("cnt_vc1", int'(cnt_vc1), 0);
`endif

        drain(20);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
